// File: rtl/dual_stream_merge_pkg.sv
// Shared types for the dual FIFO read-side merger: FSM encoding and source tags.
package merge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic SRC_1 = 1'b0;
    localparam logic SRC_2 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; last_grant moves to the granted index on advance.
module rr_arb2
    import merge_pkg::*;
(
    input  logic       clk_slow,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       last_grant
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == SRC_2) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Reset to source 2 so that source 1 wins the first contested round.
    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst)
            last_grant <= SRC_2;
        else if (advance)
            last_grant <= gnt[1];
    end

endmodule

// File: rtl/dual_stream_merge.sv
// Pops two clk_slow-synchronous FIFOs round-robin and merges them into one
// tagged valid/ready stream with per-source saturating word counters.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | output register empty, waiting for a FIFO word
//   ST_FETCH | pop issued last cycle, FIFO data arrives this cycle
//   ST_HOLD  | word presented on m_*, waiting for m_ready
module dual_stream_merge
    import merge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_slow,
    input  logic             rst,
    input  logic             empty1,
    input  logic [WIDTH-1:0] dout1,
    output logic             rd_en1,
    input  logic             empty2,
    input  logic [WIDTH-1:0] dout2,
    output logic             rd_en2,
    output logic [WIDTH-1:0] m_data,
    output logic             m_src,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);

    state_t     state, state_nxt;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       last_grant;
    logic       sel;
    logic       slot_free;
    logic       pop;

    assign req       = {!empty2, !empty1};
    assign slot_free = !m_valid || m_ready;

    // The arbiter records every issued grant, so during FETCH last_grant is
    // exactly the source that was just popped.
    assign sel = last_grant;

    rr_arb2 u_arb (
        .clk_slow   (clk_slow),
        .rst        (rst),
        .req        (req),
        .advance    (pop),
        .gnt        (gnt),
        .last_grant (last_grant)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req && slot_free) begin
                    pop       = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (m_ready) begin
                    pop       = |req;
                    state_nxt = (|req) ? ST_FETCH : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // State is already IDLE during reset; keep the FIFOs untouched until release.
        if (rst)
            pop = 1'b0;
    end

    assign rd_en1 = pop && gnt[0];
    assign rd_en2 = pop && gnt[1];

    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst) begin
            m_data  <= '0;
            m_src   <= SRC_1;
            m_valid <= 1'b0;
            cnt1    <= '0;
            cnt2    <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    m_data  <= (sel == SRC_2) ? dout2 : dout1;
                    m_src   <= sel;
                    m_valid <= 1'b1;
                    if (sel == SRC_1 && !(&cnt1))
                        cnt1 <= cnt1 + CNT_W'(1);
                    if (sel == SRC_2 && !(&cnt2))
                        cnt2 <= cnt2 + CNT_W'(1);
                end
                ST_HOLD: begin
                    if (m_ready)
                        m_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dual_stream_merge.sv
// Randomized and directed bench for dual_stream_merge against a queue-based FIFO/stream model.
module tb_dual_stream_merge;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic             clk_slow = 1'b0;
    logic             rst      = 1'b1;
    logic             empty1   = 1'b1;
    logic             empty2   = 1'b1;
    logic [WIDTH-1:0] dout1    = '0;
    logic [WIDTH-1:0] dout2    = '0;
    logic             m_ready  = 1'b0;

    logic             rd_en1, rd_en2, m_valid, m_src;
    logic [WIDTH-1:0] m_data;
    logic [CNT_W-1:0] cnt1, cnt2;

    logic             s_rd_en1, s_rd_en2, s_m_valid, s_m_src;
    logic [WIDTH-1:0] s_m_data;
    logic [1:0]       s_cnt1, s_cnt2;

    dual_stream_merge #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_slow(clk_slow), .rst(rst),
        .empty1(empty1), .dout1(dout1), .rd_en1(rd_en1),
        .empty2(empty2), .dout2(dout2), .rd_en2(rd_en2),
        .m_data(m_data), .m_src(m_src), .m_valid(m_valid), .m_ready(m_ready),
        .cnt1(cnt1), .cnt2(cnt2)
    );

    // Narrow-counter instance sees identical traffic; only its counters saturate early.
    dual_stream_merge #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
        .clk_slow(clk_slow), .rst(rst),
        .empty1(empty1), .dout1(dout1), .rd_en1(s_rd_en1),
        .empty2(empty2), .dout2(dout2), .rd_en2(s_rd_en2),
        .m_data(s_m_data), .m_src(s_m_src), .m_valid(s_m_valid), .m_ready(m_ready),
        .cnt1(s_cnt1), .cnt2(s_cnt2)
    );

    always #10 clk_slow = ~clk_slow;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] q2[$];
    logic [WIDTH-1:0] seen[$];

    bit               exp_valid, exp_src, pend_v, pend_src, last_src;
    logic [WIDTH-1:0] exp_data, pend_data;
    int               mcnt1, mcnt2, pushed1, pushed2;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_src   = 1'b0;
        exp_data  = '0;
        pend_v    = 1'b0;
        pend_src  = 1'b0;
        pend_data = '0;
        last_src  = 1'b1;
        mcnt1     = 0;
        mcnt2     = 0;
        pushed1   = 0;
        pushed2   = 0;
        q1.delete();
        q2.delete();
        seen.delete();
    endtask

    task automatic push1(input logic [WIDTH-1:0] w);
        q1.push_back(w);
        pushed1++;
    endtask

    task automatic push2(input logic [WIDTH-1:0] w);
        q2.push_back(w);
        pushed2++;
    endtask

    // Entered and left just after a rising edge: checks at the falling edge,
    // then advances the model across the next rising edge.
    task automatic tick();
        bit exp_pop, gsrc, hs;
        empty1 = (q1.size() == 0);
        empty2 = (q2.size() == 0);
        @(negedge clk_slow);
        exp_pop = !pend_v && (q1.size() > 0 || q2.size() > 0) && (!exp_valid || m_ready);
        gsrc    = (q1.size() > 0 && q2.size() > 0) ? !last_src : (q2.size() > 0);
        check_val("rd_en1", rd_en1, exp_pop && !gsrc);
        check_val("rd_en2", rd_en2, exp_pop && gsrc);
        check_val("pop_while_empty", (rd_en1 && empty1) || (rd_en2 && empty2), 0);
        check_val("m_valid", m_valid, exp_valid);
        check_val("sat_rd_en", {s_rd_en2, s_rd_en1}, {exp_pop && gsrc, exp_pop && !gsrc});
        check_val("sat_m_valid", s_m_valid, exp_valid);
        if (exp_valid) begin
            check_val("m_data", m_data, exp_data);
            check_val("m_src", m_src, exp_src);
            check_val("sat_m_data", {s_m_src, s_m_data}, {exp_src, exp_data});
        end
        check_val("cnt1", cnt1, mcnt1);
        check_val("cnt2", cnt2, mcnt2);
        check_val("sat_cnt1", s_cnt1, sat3(mcnt1));
        check_val("sat_cnt2", s_cnt2, sat3(mcnt2));
        if (m_valid && m_ready)
            seen.push_back(m_data);
        hs = exp_valid && m_ready;
        @(posedge clk_slow);
        if (pend_v) begin
            exp_valid = 1'b1;
            exp_data  = pend_data;
            exp_src   = pend_src;
            if (pend_src) mcnt2++;
            else          mcnt1++;
            pend_v = 1'b0;
        end else if (hs) begin
            exp_valid = 1'b0;
        end
        if (exp_pop) begin
            last_src  = gsrc;
            pend_v    = 1'b1;
            pend_src  = gsrc;
            pend_data = gsrc ? q2.pop_front() : q1.pop_front();
        end
        #1;
        dout1  = (exp_pop && !gsrc) ? pend_data : WIDTH'($urandom);
        dout2  = (exp_pop && gsrc)  ? pend_data : WIDTH'($urandom);
        empty1 = (q1.size() == 0);
        empty2 = (q2.size() == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        empty1 = 1'b1;
        empty2 = 1'b1;
        @(posedge clk_slow);
        @(posedge clk_slow);
        #1;
        rst = 1'b0;
    endtask

    logic [WIDTH-1:0] ord[6];

    initial begin
        ord = '{8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
        model_reset();
        rst = 1'b1;
        @(posedge clk_slow);
        #1;
        check_val("rst_m_valid", m_valid, 0);
        check_val("rst_m_data", m_data, 0);
        check_val("rst_m_src", m_src, 0);
        check_val("rst_cnt", {cnt1, cnt2}, 0);
        check_val("rst_rd_en", {rd_en1, rd_en2}, 0);
        rst = 1'b0;

        // Saturation: five words through FIFO 2
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) push2(WIDTH'(8'h30 + i));
        repeat (14) tick();
        check_val("sat_final_cnt2", s_cnt2, 3);
        check_val("sat_final_cnt1", s_cnt1, 0);
        check_val("wide_final_cnt2", cnt2, 5);

        // FIFO 1 only
        do_reset();
        m_ready = 1'b1;
        push1(8'hA1);
        push1(8'hA2);
        repeat (8) tick();
        check_val("p1_count", seen.size(), 2);
        if (seen.size() == 2) begin
            check_val("p1_word0", seen[0], 8'hA1);
            check_val("p1_word1", seen[1], 8'hA2);
        end
        check_val("p1_cnt1", cnt1, 2);
        check_val("p1_cnt2", cnt2, 0);

        // Both FIFOs, alternating
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push1(WIDTH'(8'h11 + i));
            push2(WIDTH'(8'h21 + i));
        end
        repeat (16) tick();
        check_val("p2_count", seen.size(), 6);
        for (int i = 0; i < 6 && i < seen.size(); i++)
            check_val("p2_order", seen[i], ord[i]);

        // Backpressure, then same-cycle pop at the handshake
        do_reset();
        m_ready = 1'b0;
        push1(8'h5A);
        repeat (3) tick();
        push2(8'h77);
        repeat (10) tick();
        check_val("bp_valid", m_valid, 1);
        check_val("bp_data", m_data, 8'h5A);
        m_ready = 1'b1;
        repeat (6) tick();
        check_val("bp_seen", seen.size(), 2);
        if (seen.size() == 2)
            check_val("bp_second", seen[1], 8'h77);

        // Asynchronous reset while in FETCH
        do_reset();
        m_ready = 1'b1;
        push1(8'hC1);
        push2(8'hC2);
        for (int i = 0; i < 8 && !pend_v; i++) tick();
        check_val("fetch_reached", pend_v, 1);
        #3;
        rst = 1'b1;
        #1;
        check_val("arst_m_valid", m_valid, 0);
        check_val("arst_rd_en", {rd_en1, rd_en2}, 0);
        check_val("arst_cnt", {cnt1, cnt2}, 0);
        model_reset();
        push1(8'hD1);
        push2(8'hD2);
        empty1 = 1'b0;
        empty2 = 1'b0;
        #1;
        check_val("arst_rd_en_held", {rd_en1, rd_en2}, 0);
        #1;
        rst = 1'b0;
        #1;
        check_val("first_grant_f1", {rd_en2, rd_en1}, 2'b01);
        repeat (8) tick();

        // Random traffic with random empties and backpressure
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 2) == 0 && q1.size() < 6) push1(WIDTH'($urandom));
            if ($urandom_range(0, 2) == 0 && q2.size() < 6) push2(WIDTH'($urandom));
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        m_ready = 1'b1;
        repeat (40) tick();
        check_val("drain_q1", q1.size(), 0);
        check_val("drain_q2", q2.size(), 0);
        check_val("drain_valid", m_valid, 0);
        check_val("total_cnt1", cnt1, pushed1);
        check_val("total_cnt2", cnt2, pushed2);
        check_val("total_seen", seen.size(), pushed1 + pushed2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
